uart_prog_loader: RTL

- Writer side of the program-ROM UART programming port: turns a byte stream from the UART receiver into the upg_* word-write interface that the program ROM consumes during download.
- Collects a framed image (sync byte, 16-bit word count, little-endian 32-bit words) and issues one single-cycle write strobe per word at consecutive word addresses from 0.
- Raises upg_done_o when the image is complete, which hands the ROM back to instruction fetch.
- Sits between the UART receiver and the program ROM in the upg_clk_i domain.

---
 rtl/upg_pkg.sv | 27 ++
 rtl/upg_timeout_cnt.sv | 34 +++
 rtl/uart_prog_loader.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/upg_pkg.sv
// Shared definitions for the UART program-ROM loader (upg_* write port).
// Holds the FSM state encoding, frame constants and byte-lane indices.
package upg_pkg;

  // Default ROM depth in 32-bit words (2^UPG_ADDR_W); shared with the ROM wrapper.
  localparam int unsigned UPG_ADDR_W = 14;

  // Frame start marker.
  localparam logic [7:0] UPG_SYNC_BYTE = 8'hA5;

  // Width of the 16-bit word-count field in the frame header.
  localparam int unsigned LEN_W = 16;

  // Byte-lane geometry of a little-endian 32-bit word.
  localparam int unsigned LANE_W     = 8;
  localparam logic [1:0]  LANE_FIRST = 2'd0;
  localparam logic [1:0]  LANE_LAST  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_DONE
  } upg_state_t;

endpackage : upg_pkg

// File: rtl/upg_timeout_cnt.sv
// Inter-byte watchdog: clearable up-counter that flags its terminal count.
// Ports:
//   i_clk        clock
//   i_rst_n      synchronous active-low reset
//   i_clr        clear counter to 0 (takes priority over counting)
//   i_en         count enable; the terminal flag is only raised while enabled
//   o_expired_c  combinational: counter has reached TIMEOUT_CYCLES-1
module upg_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired_c
);

  localparam int unsigned   CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_expired_c = i_en && (r_cnt == TERM);

  // Saturates at TERM so the flag stays up until the owner clears it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired_c) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule : upg_timeout_cnt

// File: rtl/uart_prog_loader.sv
// UART program loader: turns a framed byte stream (sync, 16-bit LE word count,
// LE 32-bit words) into single-cycle upg_* ROM word writes from address 0.
// Ports:
//   upg_clk_i    programmer clock (only clock)
//   upg_rst_n_i  synchronous active-low reset
//   rx_data_i    received byte
//   rx_valid_i   one-cycle strobe qualifying rx_data_i
//   upg_wen_o    one-cycle ROM write enable
//   upg_adr_o    ROM word address of the current write (held between writes)
//   upg_dat_o    ROM write data (held between writes)
//   upg_done_o   image complete; sticky until reset
//   upg_busy_o   frame in progress (LEN_LO, LEN_HI or DATA)
//   upg_err_o    last frame aborted; cleared by the next sync byte or reset
module uart_prog_loader
  import upg_pkg::*;
#(
  parameter int unsigned ADDR_W         = UPG_ADDR_W,
  parameter logic [7:0]  SYNC_BYTE      = UPG_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              upg_clk_i,
  input  logic              upg_rst_n_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              upg_busy_o,
  output logic              upg_err_o
);

  // One extra bit so a full 2^ADDR_W image does not wrap before the last-word compare.
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned CMP_W = LEN_W + 1;
  localparam logic [CMP_W-1:0] MAX_LEN = CMP_W'(1) << ADDR_W;

  upg_state_t          r_state;
  logic [LEN_W-1:0]    r_len;
  logic [CNT_W-1:0]    r_cnt;
  logic [1:0]          r_idx;
  logic [3*LANE_W-1:0] r_shift;
  logic                r_wen;
  logic [ADDR_W-1:0]   r_adr;
  logic [31:0]         r_dat;
  logic                r_done;
  logic                r_busy;
  logic                r_err;

  logic [LEN_W-1:0]    w_len_full;
  logic                w_last_word;
  logic                w_timeout;

  // Word count as it will be once the high byte in rx_data_i is captured.
  assign w_len_full  = {rx_data_i, r_len[7:0]};
  assign w_last_word = (CMP_W'(r_cnt) == (CMP_W'(r_len) - CMP_W'(1)));

  // Watchdog runs only mid-frame; any received byte restarts it.
  upg_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk       (upg_clk_i),
    .i_rst_n     (upg_rst_n_i),
    .i_clr       (rx_valid_i || !r_busy),
    .i_en        (r_busy),
    .o_expired_c (w_timeout)
  );

  // Frame FSM, byte assembly and address counter; r_busy tracks the mid-frame states.
  always_ff @(posedge upg_clk_i) begin
    if (!upg_rst_n_i) begin
      r_state <= ST_IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
      r_idx   <= LANE_FIRST;
      r_shift <= '0;
      r_wen   <= 1'b0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_wen <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (rx_valid_i && (rx_data_i == SYNC_BYTE)) begin
            r_state <= ST_LEN_LO;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
            r_cnt   <= '0;
          end
        end

        ST_LEN_LO: begin
          if (rx_valid_i) begin
            r_len[7:0] <= rx_data_i;
            r_state    <= ST_LEN_HI;
          end else if (w_timeout) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end
        end

        ST_LEN_HI: begin
          if (rx_valid_i) begin
            r_len[15:8] <= rx_data_i;
            r_idx       <= LANE_FIRST;
            if (w_len_full == '0) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else if (CMP_W'(w_len_full) > MAX_LEN) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end else begin
              r_state <= ST_DATA;
            end
          end else if (w_timeout) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end
        end

        ST_DATA: begin
          if (rx_valid_i) begin
            if (r_idx == LANE_LAST) begin
              // Top lane goes straight to the output register; shift register is free again.
              r_wen <= 1'b1;
              r_adr <= r_cnt[ADDR_W-1:0];
              r_dat <= {rx_data_i, r_shift};
              r_cnt <= r_cnt + CNT_W'(1);
              r_idx <= LANE_FIRST;
              if (w_last_word) begin
                r_state <= ST_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_shift[LANE_W*int'(r_idx) +: LANE_W] <= rx_data_i;
              r_idx <= r_idx + 2'd1;
            end
          end else if (w_timeout) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end
        end

        ST_DONE: begin
          // Terminal until reset; all bytes ignored.
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign upg_wen_o  = r_wen;
  assign upg_adr_o  = r_adr;
  assign upg_dat_o  = r_dat;
  assign upg_done_o = r_done;
  assign upg_busy_o = r_busy;
  assign upg_err_o  = r_err;

endmodule : uart_prog_loader
